// File: rtl/tile_map_ctl.sv
// Tile-map controller: overlays walls and pickup items on the pixel stream and,
// once per frame, scans the heroes for pickups, score, time bonuses and wall contacts.
module tile_map_ctl #(
    parameter int unsigned N_HEROES    = 2,
    parameter int unsigned TILE        = 60,
    parameter int unsigned COLS        = 15,
    parameter int unsigned ROWS        = 10,
    parameter int unsigned X_ORG       = 61,
    parameter int unsigned Y_ORG       = 108,
    parameter int unsigned COIN_PTS    = 200,
    parameter int unsigned DIAMOND_PTS = 1000,
    parameter int unsigned HOLD_TIME   = 1200000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       next_level,
    input  logic [10:0]                hcount_in,
    input  logic [10:0]                vcount_in,
    input  logic                       hsync_in,
    input  logic                       hblnk_in,
    input  logic                       vsync_in,
    input  logic                       vblnk_in,
    input  logic [11:0]                rgb_in,
    input  logic [4*COLS*ROWS-1:0]     map,
    input  logic [12*N_HEROES-1:0]     hero_x_pos,
    input  logic [12*N_HEROES-1:0]     hero_y_pos,
    output logic [10:0]                hcount_out,
    output logic [10:0]                vcount_out,
    output logic                       hsync_out,
    output logic                       hblnk_out,
    output logic                       vsync_out,
    output logic                       vblnk_out,
    output logic [11:0]                rgb_out,
    output logic [4*N_HEROES-1:0]      collision,
    output logic [23:0]                score_out,
    output logic                       add_time,
    output logic                       level_clear
);

    localparam int unsigned NT     = COLS * ROWS;
    localparam int unsigned GRID_W = COLS * TILE;
    localparam int unsigned GRID_H = ROWS * TILE;
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned OFF_W  = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int unsigned IDX_W  = (NT > 1) ? $clog2(NT) : 1;
    localparam int unsigned H_W    = (N_HEROES > 1) ? $clog2(N_HEROES) : 1;
    localparam int unsigned CNT_W  = $clog2(HOLD_TIME + 1);
    localparam int unsigned NC     = 4 * N_HEROES;
    localparam int unsigned VID_W  = 26;

    localparam logic [3:0]  T_WALL    = 4'd1;
    localparam logic [3:0]  T_COIN    = 4'd2;
    localparam logic [3:0]  T_DIAMOND = 4'd3;
    localparam logic [3:0]  T_TIME    = 4'd4;
    localparam logic [11:0] C_WALL    = 12'h630;
    localparam logic [11:0] C_COIN    = 12'hfc0;
    localparam logic [11:0] C_DIAMOND = 12'h0ff;
    localparam logic [11:0] C_TIME    = 12'h0c0;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCAN, S_PICK} state_t;

    logic [3:0]  tiles  [NT];
    logic [11:0] hero_x [N_HEROES];
    logic [11:0] hero_y [N_HEROES];

    for (genvar g = 0; g < NT; g++) begin : g_tiles
        assign tiles[g] = map[4*g +: 4];
    end
    for (genvar g = 0; g < N_HEROES; g++) begin : g_heroes
        assign hero_x[g] = hero_x_pos[12*g +: 12];
        assign hero_y[g] = hero_y_pos[12*g +: 12];
    end

    // Render pipeline registers
    logic              in1_d, in1_q;
    logic [COL_W-1:0]  col1_d, col1_q;
    logic [ROW_W-1:0]  row1_d, row1_q;
    logic [OFF_W-1:0]  ox1_d, ox1_q, oy1_d, oy1_q;
    logic [11:0]       rgb1_d, rgb1_q, rgb2_d, rgb2_q;
    logic [VID_W-1:0]  vid1_d, vid1_q, vid2_d, vid2_q;
    int unsigned       px, py;
    logic [IDX_W-1:0]  pix_idx;
    logic [3:0]        pix_code;
    logic              pix_win;

    // Scan state
    state_t            state_d, state_q;
    logic [H_W-1:0]    h_d, h_q;
    logic [IDX_W-1:0]  pick_idx_d, pick_idx_q;
    logic [3:0]        pick_code_d, pick_code_q;
    logic [NT-1:0]     picked_d, picked_q;
    logic [23:0]       score_d, score_q;
    logic              add_time_d, add_time_q;
    logic              level_clear_d, level_clear_q;
    logic              vblnk_prev_d, vblnk_prev_q;
    logic [CNT_W-1:0]  cnt_d [NC];
    logic [CNT_W-1:0]  cnt_q [NC];
    logic [NC-1:0]     coll_d, coll_q;
    logic              upd_lc, load_det, advance, remain;
    logic [24:0]       sum;

    int unsigned       hx, hy, cx, cy, t_col, t_row, t_xo, t_yo, t_idx;
    logic              c_in, t_in, c_item;
    logic [IDX_W-1:0]  c_idx;
    logic [3:0]        c_code;
    logic [3:0]        det;

    // Stage 1: grid position of the incoming pixel
    always_comb begin
        px     = 32'(hcount_in) - X_ORG;
        py     = 32'(vcount_in) - Y_ORG;
        vid1_d = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
        rgb1_d = rgb_in;
        in1_d  = (32'(hcount_in) >= X_ORG) && (px < GRID_W) &&
                 (32'(vcount_in) >= Y_ORG) && (py < GRID_H);
        col1_d = '0;
        row1_d = '0;
        ox1_d  = '0;
        oy1_d  = '0;
        if (in1_d) begin
            col1_d = COL_W'(px / TILE);
            row1_d = ROW_W'(py / TILE);
            ox1_d  = OFF_W'(px % TILE);
            oy1_d  = OFF_W'(py % TILE);
        end
    end

    // Stage 2: tile colour selection
    always_comb begin
        pix_idx  = IDX_W'(32'(col1_q) + 32'(row1_q) * COLS);
        pix_code = tiles[pix_idx];
        pix_win  = (32'(ox1_q) >= TILE / 4) && (32'(ox1_q) < 3 * TILE / 4) &&
                   (32'(oy1_q) >= TILE / 4) && (32'(oy1_q) < 3 * TILE / 4);
        vid2_d   = vid1_q;
        rgb2_d   = rgb1_q;
        if (in1_q) begin
            if (pix_code == T_WALL) begin
                rgb2_d = C_WALL;
            end else if (pix_win && !picked_q[pix_idx]) begin
                case (pix_code)
                    T_COIN:    rgb2_d = C_COIN;
                    T_DIAMOND: rgb2_d = C_DIAMOND;
                    T_TIME:    rgb2_d = C_TIME;
                    default:   ;
                endcase
            end
        end
    end

    // Per-hero centre-tile lookup and wall-contact detection
    always_comb begin
        hx     = 32'(hero_x[h_q]);
        hy     = 32'(hero_y[h_q]);
        cx     = hx + TILE / 2 - X_ORG;
        cy     = hy + TILE / 2 - Y_ORG;
        c_in   = (hx + TILE / 2 >= X_ORG) && (cx < GRID_W) &&
                 (hy + TILE / 2 >= Y_ORG) && (cy < GRID_H);
        c_idx  = IDX_W'(cx / TILE + (cy / TILE) * COLS);
        c_code = tiles[c_idx];
        c_item = c_in && !picked_q[c_idx] &&
                 (c_code == T_COIN || c_code == T_DIAMOND || c_code == T_TIME);

        t_in   = (hx >= X_ORG) && (hx - X_ORG < GRID_W) &&
                 (hy >= Y_ORG) && (hy - Y_ORG < GRID_H);
        t_col  = (hx - X_ORG) / TILE;
        t_row  = (hy - Y_ORG) / TILE;
        t_xo   = (hx - X_ORG) % TILE;
        t_yo   = (hy - Y_ORG) % TILE;
        t_idx  = t_col + t_row * COLS;
        det    = '0;
        if (t_in) begin
            det[0] = (t_xo == 0) && ((t_col == 0) ? 1'b1 :
                     (tiles[IDX_W'(t_idx - 1)] == T_WALL));
            det[1] = (t_xo == 0) && ((t_col == COLS - 1) ? 1'b1 :
                     (tiles[IDX_W'(t_idx + 1)] == T_WALL));
            det[2] = (t_yo == 0) && ((t_row == ROWS - 1) ? 1'b1 :
                     (tiles[IDX_W'(t_idx + COLS)] == T_WALL));
            det[3] = (t_yo == 0) && ((t_row == 0) ? 1'b1 :
                     (tiles[IDX_W'(t_idx - COLS)] == T_WALL));
        end
    end

    // Scan FSM: next state, pickups and score
    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        pick_idx_d   = pick_idx_q;
        pick_code_d  = pick_code_q;
        picked_d     = picked_q;
        score_d      = score_q;
        add_time_d   = 1'b0;
        upd_lc       = 1'b0;
        load_det     = 1'b0;
        advance      = 1'b0;
        vblnk_prev_d = vblnk_in;
        sum          = '0;
        if (next_level) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    picked_d = '0;
                    upd_lc   = 1'b1;
                    state_d  = S_IDLE;
                end
                S_IDLE: begin
                    if (vblnk_in && !vblnk_prev_q) begin
                        h_d     = '0;
                        state_d = S_SCAN;
                    end
                end
                S_SCAN: begin
                    load_det = 1'b1;
                    if (c_item) begin
                        pick_idx_d  = c_idx;
                        pick_code_d = c_code;
                        state_d     = S_PICK;
                    end else begin
                        advance = 1'b1;
                    end
                end
                S_PICK: begin
                    picked_d[pick_idx_q] = 1'b1;
                    case (pick_code_q)
                        T_COIN:    sum = {1'b0, score_q} + 25'(COIN_PTS);
                        T_DIAMOND: sum = {1'b0, score_q} + 25'(DIAMOND_PTS);
                        default:   sum = {1'b0, score_q};
                    endcase
                    score_d    = sum[24] ? 24'hFFFFFF : sum[23:0];
                    add_time_d = (pick_code_q == T_TIME);
                    advance    = 1'b1;
                end
                default: state_d = S_CLEAR;
            endcase
            if (advance) begin
                if (32'(h_q) == N_HEROES - 1) begin
                    state_d = S_IDLE;
                    upd_lc  = 1'b1;
                end else begin
                    h_d     = h_q + H_W'(1);
                    state_d = S_SCAN;
                end
            end
        end
    end

    // Level-clear evaluation against the post-update picked set
    always_comb begin
        remain = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if ((tiles[i] == T_COIN || tiles[i] == T_DIAMOND) && !picked_d[i]) begin
                remain = 1'b1;
            end
        end
        level_clear_d = upd_lc ? !remain : level_clear_q;
    end

    // Collision hold counters: reload on detection, otherwise count down
    always_comb begin
        for (int i = 0; i < NC; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
            if (load_det && (32'(i) >> 2) == 32'(h_q) && det[i[1:0]]) begin
                cnt_d[i] = CNT_W'(HOLD_TIME);
            end
            coll_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            in1_q         <= 1'b0;
            col1_q        <= '0;
            row1_q        <= '0;
            ox1_q         <= '0;
            oy1_q         <= '0;
            rgb1_q        <= '0;
            vid1_q        <= '0;
            rgb2_q        <= '0;
            vid2_q        <= '0;
            state_q       <= S_CLEAR;
            h_q           <= '0;
            pick_idx_q    <= '0;
            pick_code_q   <= '0;
            picked_q      <= '0;
            score_q       <= '0;
            add_time_q    <= 1'b0;
            level_clear_q <= 1'b0;
            vblnk_prev_q  <= 1'b0;
            coll_q        <= '0;
            for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
        end else begin
            in1_q         <= in1_d;
            col1_q        <= col1_d;
            row1_q        <= row1_d;
            ox1_q         <= ox1_d;
            oy1_q         <= oy1_d;
            rgb1_q        <= rgb1_d;
            vid1_q        <= vid1_d;
            rgb2_q        <= rgb2_d;
            vid2_q        <= vid2_d;
            state_q       <= state_d;
            h_q           <= h_d;
            pick_idx_q    <= pick_idx_d;
            pick_code_q   <= pick_code_d;
            picked_q      <= picked_d;
            score_q       <= score_d;
            add_time_q    <= add_time_d;
            level_clear_q <= level_clear_d;
            vblnk_prev_q  <= vblnk_prev_d;
            coll_q        <= coll_d;
            for (int i = 0; i < NC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} = vid2_q;
    assign rgb_out     = rgb2_q;
    assign collision   = coll_q;
    assign score_out   = score_q;
    assign add_time    = add_time_q;
    assign level_clear = level_clear_q;

endmodule

// File: doc/tile_map_ctl.md
# tile_map_ctl

Parametrised tile-map controller for the play field. It draws walls and pickup items from a flat map vector onto the pixel stream, with configurable tile size, grid size, origin and hero count. Once per frame it runs a sequential scan that resolves item pickups, score and time bonuses, and per-hero wall contacts. It sits in the video chain between the background stage and the hero sprite stage, and feeds the hero movement controllers and the score/timer logic.

## Interface
- N_HEROES, 2, number of heroes scanned (1..4)
- TILE, 60, tile side in pixels (multiple of 4)
- COLS, 15, grid columns
- ROWS, 10, grid rows
- X_ORG, 61, x pixel of grid column 0
- Y_ORG, 108, y pixel of grid row 0
- COIN_PTS, 200, score added per coin
- DIAMOND_PTS, 1000, score added per diamond
- HOLD_TIME, 1200000, cycles a collision bit is held after its last detection

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  reset, synchronous, active-low
- next_level  in  1  level restart request (pulse)
- hcount_in, vcount_in  in  11 each  pixel counters
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing signals
- rgb_in  in  12  upstream pixel colour
- map  in  4*COLS*ROWS  tile codes; tile i = col + row*COLS occupies bits [4i+3:4i]
- hero_x_pos, hero_y_pos  in  12*N_HEROES each  hero top-left pixel; hero h occupies bits [12h+11:12h]
- hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out  out  as inputs  timing delayed by 2 cycles
- rgb_out  out  12  composed pixel
- collision  out  4*N_HEROES  per hero h, bits [4h+3:4h] = {up, down, right, left}, held
- score_out  out  24  accumulated score
- add_time  out  1  one-cycle pulse per time-bonus pickup
- level_clear  out  1  high while no unpicked coin or diamond remains

## Operation
- Tile codes: 0 BLANK, 1 WALL (colour 12'h630), 2 COIN (12'hfc0), 3 DIAMOND (12'h0ff), 4 ADD_TIME (12'h0c0). Codes 5..15 are treated as BLANK.
- Render pipeline:
  - Stage 1 registers the in-grid flag, col = (hcount-X_ORG)/TILE, row = (vcount-Y_ORG)/TILE, the in-tile offsets ox and oy, and rgb_in.
  - Stage 2 outputs the result:
    - WALL: wall colour over the whole tile.
    - Item tile that is not picked, with TILE/4 <= ox,oy < 3*TILE/4: the item colour.
    - Everything else, including pixels outside the grid: the delayed rgb_in.
- picked: a COLS*ROWS-bit register; a set bit hides the item and blocks a second pickup.
- Scan FSM states:
  - CLEAR: picked <= 0; go to IDLE.
  - IDLE: on the rising edge of vblnk_in, set h = 0 and go to SCAN.
  - SCAN: one cycle per hero.
    - Centre tile = tile containing (x+TILE/2, y+TILE/2). A centre outside the grid never causes a pickup.
    - If the centre tile is an item and not picked, go to PICK; otherwise go to the next hero.
    - In the same cycle, compute the collision detect bits. left = (x-X_ORG) mod TILE == 0 and the tile at col-1 is WALL or col == 0. right, up and down are symmetric, using the tile edges and the grid bounds.
  - PICK: set the picked bit. COIN adds COIN_PTS. DIAMOND adds DIAMOND_PTS. ADD_TIME pulses add_time and leaves the score unchanged. Then go to the next hero.
  - After hero N_HEROES-1, return to IDLE.
- Collision hold: each bit has its own counter. Detection loads HOLD_TIME; the counter otherwise decrements to 0. The output bit is 1 while the counter is nonzero.
- level_clear = no tile has code 2 or 3 with its picked bit clear. It is recomputed at every scan end and at CLEAR.

## Timing
- Reset values:
  - All outputs 0, except level_clear, which is computed at the first CLEAR.
  - picked = 0, counters = 0, FSM = CLEAR.
- Video latency is exactly 2 cycles for rgb and all timing signals.
- Scan time is N_HEROES + (number of pickups) cycles, at most 2*N_HEROES. It completes well within vblank.
- next_level has priority in any state: the FSM goes to CLEAR on the next cycle and any scan in progress is aborted. Score is kept; only reset clears it. Collision counters keep running.
- Score saturates at 24'hFFFFFF; there is no wrap-around.
- Two heroes on the same item in one scan: only the lower index picks it and is scored once, because the picked bit is set before the higher hero is evaluated.
- A vblnk rising edge during SCAN or PICK is ignored.
- Reset asserted mid-scan: all state returns to reset values on the next clk edge.

## Test plan
- Reset release with TILE=60 and map tile 0 = WALL: pixel (61,108) gives rgb_out 12'h630 exactly 2 cycles after the pixel enters; pixel (0,0) gives rgb_out equal to rgb_in.
- COIN at tile 16 and hero 0 at (121,168): after the next vblank, score_out = 200, the coin is no longer drawn, and later frames do not change the score.
- Heroes 0 and 1 both centred on a DIAMOND: score_out rises by 1000 only, and the scan takes 3 cycles.
- ADD_TIME tile under hero 1: add_time is high for exactly 1 cycle and score is unchanged.
- Hero 0 at (121,168) with WALL at tile 15: collision[0] = 1. Hero moved away: collision[0] stays 1 for HOLD_TIME=8 cycles (test override), then drops to 0.
- Map with a single coin, picked: level_clear = 1. Then next_level pulses: picked is cleared, level_clear = 0, the coin is drawn again, and score_out is unchanged.
